// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: instruction-type encodings and per-entry status flags.
package rob_pkg;

  typedef enum logic [1:0] {
    TYPE_REG = 2'b00,
    TYPE_BR  = 2'b01,
    TYPE_ST  = 2'b10
  } inst_type_e;

  // Status half of a ROB entry; wide payload (rd_reg, pc, data) lives in parameterised arrays.
  typedef struct packed {
    inst_type_e itype;
    logic       done;
    logic       taken;
  } rob_entry_t;

endpackage

// File: rtl/rob_rename_table.sv
// Register rename table: per architectural register a busy bit and the producing ROB tag.
// Two lookup ports, one set port, one tag-guarded clear port and a global flush.
module rob_rename_table #(
  parameter int REG_W = 5,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] rd_a_reg,
  input  logic [REG_W-1:0] rd_b_reg,
  output logic             rd_a_busy,
  output logic             rd_b_busy,
  output logic [TAG_W-1:0] rd_a_tag,
  output logic [TAG_W-1:0] rd_b_tag,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_reg,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic             flush
);

  localparam int NREG = 1 << REG_W;

  logic [NREG-1:0]  busy_reg;
  logic [TAG_W-1:0] tag_reg [NREG];

  assign rd_a_busy = busy_reg[rd_a_reg];
  assign rd_b_busy = busy_reg[rd_b_reg];
  assign rd_a_tag  = tag_reg[rd_a_reg];
  assign rd_b_tag  = tag_reg[rd_b_reg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_reg <= '0;
      for (int i = 0; i < NREG; i++) tag_reg[i] <= '0;
    end else if (flush) begin
      busy_reg <= '0;
    end else begin
      // Clear only if no younger producer has renamed the register since.
      if (clr_en && busy_reg[clr_reg] && (tag_reg[clr_reg] == clr_tag))
        busy_reg[clr_reg] <= 1'b0;
      // A same-cycle rename of the same register wins over the clear.
      if (set_en && (set_reg != '0)) begin
        busy_reg[set_reg] <= 1'b1;
        tag_reg[set_reg]  <= set_tag;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue with in-order retire, CDB writeback and register renaming.
// Optional macro ROB_FLUSH_EN: retiring a mispredicted branch flushes all younger state.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_valid,
  input  logic [REG_W-1:0]  disp_rd_reg,
  input  logic [DATA_W-1:0] disp_pc,
  input  logic [1:0]        disp_type,
  output logic              disp_ready,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic [REG_W-1:0]  rs_reg,
  input  logic [REG_W-1:0]  rt_reg,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [TAG_W-1:0]  rs_tag,
  output logic [TAG_W-1:0]  rt_tag,
  output logic              rs_data_valid,
  output logic              rt_data_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_branch_taken,
  output logic              retire_valid,
  output logic [TAG_W-1:0]  retire_tag,
  output logic [REG_W-1:0]  retire_rd_reg,
  output logic [DATA_W-1:0] retire_data,
  output logic [DATA_W-1:0] retire_pc,
  output logic              retire_branch,
  output logic              retire_branch_taken,
  output logic              retire_store_ready,
  output logic              retire_flush,
  output logic              empty,
  output logic              full
);

  logic [TAG_W-1:0]  head_reg, tail_reg;
  logic [TAG_W:0]    count_reg;
  rob_entry_t        entry_reg [DEPTH];
  logic [REG_W-1:0]  rd_mem    [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];

  rob_entry_t       head_entry;
  logic             disp_fire, retire_fire, flush_fire, cdb_hit;
  logic [TAG_W-1:0] cdb_off;

  assign full       = (count_reg == (TAG_W+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign disp_ready = !full;
  assign disp_tag   = tail_reg;

  assign head_entry  = entry_reg[head_reg];
  assign disp_fire   = disp_valid && !full;
  assign retire_fire = !empty && head_entry.done;
  // An entry is live when its distance from head (modulo DEPTH) is below count.
  assign cdb_off     = cdb_tag - head_reg;
  assign cdb_hit     = cdb_valid && ({1'b0, cdb_off} < count_reg);

`ifdef ROB_FLUSH_EN
  assign flush_fire = retire_fire && (head_entry.itype == TYPE_BR) && head_entry.taken;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) retire_flush <= 1'b0;
    else       retire_flush <= flush_fire;
  end
`else
  assign flush_fire   = 1'b0;
  assign retire_flush = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else if (flush_fire) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i].done <= 1'b0;
    end else begin
      if (disp_fire) begin
        entry_reg[tail_reg] <= '{itype: inst_type_e'(disp_type), done: 1'b0, taken: 1'b0};
        tail_reg            <= tail_reg + 1'b1;
      end
      // Tail is never live when dispatch fires, so these two writes never collide.
      if (cdb_hit) begin
        entry_reg[cdb_tag].done  <= 1'b1;
        entry_reg[cdb_tag].taken <= cdb_branch_taken;
      end
      if (retire_fire) head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(retire_fire);
    end
  end

  always_ff @(posedge clock) begin
    if (disp_fire) begin
      rd_mem[tail_reg] <= disp_rd_reg;
      pc_mem[tail_reg] <= disp_pc;
    end
    if (cdb_hit) data_mem[cdb_tag] <= cdb_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_valid        <= 1'b0;
      retire_tag          <= '0;
      retire_rd_reg       <= '0;
      retire_data         <= '0;
      retire_pc           <= '0;
      retire_branch       <= 1'b0;
      retire_branch_taken <= 1'b0;
      retire_store_ready  <= 1'b0;
    end else begin
      retire_valid <= retire_fire;
      if (retire_fire) begin
        retire_tag          <= head_reg;
        retire_rd_reg       <= rd_mem[head_reg];
        retire_data         <= data_mem[head_reg];
        retire_pc           <= pc_mem[head_reg];
        retire_branch       <= (head_entry.itype == TYPE_BR);
        retire_branch_taken <= (head_entry.itype == TYPE_BR) && head_entry.taken;
        retire_store_ready  <= (head_entry.itype == TYPE_ST);
      end
    end
  end

  // Source data: the entry's result, or the value on the CDB this very cycle.
  assign rs_data_valid = entry_reg[rs_tag].done || (cdb_valid && (cdb_tag == rs_tag));
  assign rt_data_valid = entry_reg[rt_tag].done || (cdb_valid && (cdb_tag == rt_tag));
  assign rs_data = (cdb_valid && (cdb_tag == rs_tag)) ? cdb_data : data_mem[rs_tag];
  assign rt_data = (cdb_valid && (cdb_tag == rt_tag)) ? cdb_data : data_mem[rt_tag];

  rob_rename_table #(.REG_W(REG_W), .TAG_W(TAG_W)) u_rename (
    .clock     (clock),
    .reset     (reset),
    .rd_a_reg  (rs_reg),
    .rd_b_reg  (rt_reg),
    .rd_a_busy (rs_busy),
    .rd_b_busy (rt_busy),
    .rd_a_tag  (rs_tag),
    .rd_b_tag  (rt_tag),
    .set_en    (disp_fire && (disp_type == TYPE_REG)),
    .set_reg   (disp_rd_reg),
    .set_tag   (tail_reg),
    .clr_en    (retire_fire && (head_entry.itype == TYPE_REG)),
    .clr_reg   (rd_mem[head_reg]),
    .clr_tag   (head_reg),
    .flush     (flush_fire)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
// Flush scenario and flush modelling are active when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TAG_W  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              disp_valid, disp_ready;
  logic [REG_W-1:0]  disp_rd_reg;
  logic [DATA_W-1:0] disp_pc;
  logic [1:0]        disp_type;
  logic [TAG_W-1:0]  disp_tag;
  logic [REG_W-1:0]  rs_reg, rt_reg;
  logic              rs_busy, rt_busy, rs_data_valid, rt_data_valid;
  logic [TAG_W-1:0]  rs_tag, rt_tag;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              cdb_valid, cdb_branch_taken;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              retire_valid, retire_branch, retire_branch_taken;
  logic              retire_store_ready, retire_flush, empty, full;
  logic [TAG_W-1:0]  retire_tag;
  logic [REG_W-1:0]  retire_rd_reg;
  logic [DATA_W-1:0] retire_data, retire_pc;

  always #5 clock = ~clock;

  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_rd_reg(disp_rd_reg), .disp_pc(disp_pc), .disp_type(disp_type),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .rs_reg(rs_reg), .rt_reg(rt_reg), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rs_tag(rs_tag), .rt_tag(rt_tag), .rs_data_valid(rs_data_valid), .rt_data_valid(rt_data_valid),
    .rs_data(rs_data), .rt_data(rt_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_branch_taken(cdb_branch_taken),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_rd_reg(retire_rd_reg),
    .retire_data(retire_data), .retire_pc(retire_pc), .retire_branch(retire_branch),
    .retire_branch_taken(retire_branch_taken), .retire_store_ready(retire_store_ready),
    .retire_flush(retire_flush), .empty(empty), .full(full)
  );

  // Reference model: in-flight instructions oldest first, plus a rename map.
  typedef struct {
    int          tag;
    int          rd;
    logic [31:0] pc;
    int          typ;
    bit          done;
    logic [31:0] data;
    bit          taken;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_tail;
  bit     ren_busy [32];
  int     ren_tag  [32];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_tail = 0;
    for (int i = 0; i < 32; i++) begin
      ren_busy[i] = 1'b0;
      ren_tag[i]  = 0;
    end
  endfunction

  function automatic int find(input int tag);
    for (int i = 0; i < m_q.size(); i++)
      if (m_q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic check_lookup(input string nm, input int rg, input logic busy, input logic [TAG_W-1:0] tg,
                              input logic dv, input logic [DATA_W-1:0] d);
    int idx;
    bit byp, rdy;
    chk({nm, "_busy"}, busy, ren_busy[rg]);
    if (ren_busy[rg]) begin
      chk({nm, "_tag"}, tg, ren_tag[rg]);
      idx = find(ren_tag[rg]);
      byp = cdb_valid && (int'(cdb_tag) == ren_tag[rg]);
      rdy = (idx >= 0) && m_q[idx].done;
      chk({nm, "_data_valid"}, dv, byp || rdy);
      if (byp) chk({nm, "_data_bypass"}, d, cdb_data);
      else if (rdy) chk({nm, "_data"}, d, m_q[idx].data);
    end
  endtask

  task automatic set_disp(input bit v, input int typ, input int rd);
    disp_valid  = v;
    disp_type   = 2'(typ);
    disp_rd_reg = REG_W'(rd);
    disp_pc     = $urandom();
  endtask

  task automatic set_cdb(input bit v, input int tag, input logic [31:0] d, input bit tk);
    cdb_valid        = v;
    cdb_tag          = TAG_W'(tag);
    cdb_data         = d;
    cdb_branch_taken = tk;
  endtask

  task automatic idle();
    set_disp(1'b0, 0, 0);
    set_cdb(1'b0, 0, 32'h0, 1'b0);
  endtask

  // One clock: check combinational outputs, clock, advance the model, check retire outputs.
  task automatic step();
    bit     exp_full, exp_ret, exp_flush, dsp, cv, ctk;
    int     ctag, ci, drd, dtyp;
    logic [31:0] cdat, dpc;
    m_ent_t r;
    m_ent_t n;
    #1;
    exp_full = (m_q.size() == DEPTH);
    chk("full", full, exp_full);
    chk("empty", empty, m_q.size() == 0);
    chk("disp_ready", disp_ready, !exp_full);
    chk("disp_tag", disp_tag, m_tail);
    check_lookup("rs", int'(rs_reg), rs_busy, rs_tag, rs_data_valid, rs_data);
    check_lookup("rt", int'(rt_reg), rt_busy, rt_tag, rt_data_valid, rt_data);
    exp_ret = (m_q.size() > 0) && m_q[0].done;
    if (exp_ret) r = m_q[0];
    exp_flush = 1'b0;
`ifdef ROB_FLUSH_EN
    exp_flush = exp_ret && (r.typ == 1) && r.taken;
`endif
    dsp  = disp_valid && !exp_full;
    drd  = int'(disp_rd_reg);
    dtyp = int'(disp_type);
    dpc  = disp_pc;
    cv   = cdb_valid;
    ctag = int'(cdb_tag);
    cdat = cdb_data;
    ctk  = cdb_branch_taken;
    @(posedge clock);
    #1;
    if (exp_flush) begin
      m_reset();
    end else begin
      if (cv) begin
        ci = find(ctag);
        if (ci >= 0) begin
          m_q[ci].done  = 1'b1;
          m_q[ci].data  = cdat;
          m_q[ci].taken = ctk;
        end
      end
      if (exp_ret) begin
        void'(m_q.pop_front());
        if (ren_busy[r.rd] && ren_tag[r.rd] == r.tag) ren_busy[r.rd] = 1'b0;
      end
      if (dsp) begin
        n = '{tag: m_tail, rd: drd, pc: dpc, typ: dtyp, done: 1'b0, data: 32'h0, taken: 1'b0};
        m_q.push_back(n);
        if (dtyp == 0 && drd != 0) begin
          ren_busy[drd] = 1'b1;
          ren_tag[drd]  = m_tail;
        end
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    chk("retire_valid", retire_valid, exp_ret);
    chk("retire_flush", retire_flush, exp_flush);
    if (exp_ret) begin
      chk("retire_tag", retire_tag, r.tag);
      chk("retire_rd_reg", retire_rd_reg, r.rd);
      chk("retire_data", retire_data, r.data);
      chk("retire_pc", retire_pc, r.pc);
      chk("retire_branch", retire_branch, r.typ == 1);
      chk("retire_branch_taken", retire_branch_taken, (r.typ == 1) && r.taken);
      chk("retire_store_ready", retire_store_ready, r.typ == 2);
      $display("retire tag=%0d rd=%0d type=%0d data=%08h taken=%0d flush=%0d",
               r.tag, r.rd, r.typ, r.data, r.taken, exp_flush);
    end
  endtask

  task automatic do_reset();
    idle();
    #2 reset = 1'b1;
    #1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_retire_valid", retire_valid, 1'b0);
    chk("rst_retire_flush", retire_flush, 1'b0);
    chk("rst_disp_tag", disp_tag, 0);
    chk("rst_rs_busy", rs_busy, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic drain();
    int pend;
    for (int i = 0; i < 3 * DEPTH && m_q.size() > 0; i++) begin
      pend = -1;
      for (int k = 0; k < m_q.size(); k++)
        if (!m_q[k].done && pend < 0) pend = k;
      set_disp(1'b0, 0, 0);
      if (pend >= 0) set_cdb(1'b1, m_q[pend].tag, $urandom(), 1'b0);
      else           set_cdb(1'b0, 0, 32'h0, 1'b0);
      step();
    end
    idle();
    #1 chk("drain_empty", empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, sel;
    reset = 1'b1;
    rs_reg = '0;
    rt_reg = '0;
    idle();
    m_reset();
    do_reset();

    // Three register ops to r1..r3 take tags 0..2.
    for (int i = 0; i < 3; i++) begin
      set_disp(1'b1, 0, i + 1);
      chk("first_tags", disp_tag, i);
      step();
    end
    idle();
    rs_reg = 5'd2;
    #1;
    chk("r2_busy", rs_busy, 1'b1);
    chk("r2_tag", rs_tag, 1);
    chk("r2_data_valid", rs_data_valid, 1'b0);
    step();

    // Out-of-order completion still retires in order.
    set_cdb(1'b1, 1, 32'hAB, 1'b0);
    step();
    chk("no_early_retire", retire_valid, 1'b0);
    set_cdb(1'b1, 0, 32'h11, 1'b0);
    step();
    chk("cdb_head_no_retire", retire_valid, 1'b0);
    idle();
    step();
    chk("ret0_valid", retire_valid, 1'b1);
    chk("ret0_tag", retire_tag, 0);
    chk("ret0_data", retire_data, 32'h11);
    step();
    chk("ret1_valid", retire_valid, 1'b1);
    chk("ret1_tag", retire_tag, 1);
    chk("ret1_data", retire_data, 32'hAB);

    // CDB bypass into a same-cycle lookup of tag 3.
    set_disp(1'b1, 0, 4);
    step();
    idle();
    rs_reg = 5'd4;
    set_cdb(1'b1, 3, 32'h55, 1'b0);
    #1;
    chk("bypass_valid", rs_data_valid, 1'b1);
    chk("bypass_data", rs_data, 32'h55);
    step();
    drain();

    // r5 renamed twice; retiring the older producer keeps the younger mapping.
    set_disp(1'b1, 0, 5);
    chk("r5_tag4", disp_tag, 4);
    step();
    set_disp(1'b1, 0, 5);
    chk("r5_tag5", disp_tag, 5);
    step();
    idle();
    set_cdb(1'b1, 4, $urandom(), 1'b0);
    step();
    idle();
    step();
    rs_reg = 5'd5;
    #1;
    chk("r5_still_busy", rs_busy, 1'b1);
    chk("r5_young_tag", rs_tag, 5);
    drain();

    // Fill to DEPTH, overflow attempt, then slot reuse across the wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(1'b1, $urandom_range(0, 2), $urandom_range(1, 7));
      step();
    end
    #1;
    chk("fill_full", full, 1'b1);
    chk("fill_ready", disp_ready, 1'b0);
    set_disp(1'b1, 0, 3);
    step();
    chk("overflow_tail", disp_tag, 0);
    chk("overflow_full", full, 1'b1);
    idle();
    set_cdb(1'b1, 0, 32'hC0DE, 1'b0);
    step();
    set_disp(1'b1, 0, 6);
    step();
    chk("after_retire_notfull", full, 1'b0);
    set_disp(1'b1, 0, 6);
    chk("wrap_reuse_tag0", disp_tag, 0);
    step();
    chk("wrap_refull", full, 1'b1);
    chk("wrap_tail", disp_tag, 1);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      set_disp($urandom_range(0, 9) < 6, $urandom_range(0, 2), $urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      if (sel < 4 && m_q.size() > 0) begin
        k = $urandom_range(0, m_q.size() - 1);
        set_cdb(1'b1, m_q[k].tag, $urandom(), $urandom_range(0, 15) == 0);
      end else if (sel == 4 && m_q.size() < DEPTH) begin
        set_cdb(1'b1, m_tail, $urandom(), 1'b0);
      end else begin
        set_cdb(1'b0, 0, 32'h0, 1'b0);
      end
      rs_reg = REG_W'($urandom_range(0, 7));
      rt_reg = REG_W'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset in the middle of traffic discards everything.
    do_reset();
    step();

`ifdef ROB_FLUSH_EN
    // Mispredicted branch at head with four younger entries flushes the ROB.
    set_disp(1'b1, 1, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_disp(1'b1, 0, i + 1);
      step();
    end
    set_disp(1'b0, 0, 0);
    set_cdb(1'b1, 0, 32'h0, 1'b1);
    step();
    set_disp(1'b1, 0, 2);
    set_cdb(1'b1, 2, 32'h77, 1'b0);
    step();
    chk("flush_pulse", retire_flush, 1'b1);
    chk("flush_empty", empty, 1'b1);
    chk("flush_disp_tag", disp_tag, 0);
    idle();
    step();
    chk("flush_one_cycle", retire_flush, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of ROB entries (power of 2, 4..64).
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of result data and PC.
REQ-003 SHALL have parameter REG_W, default 5, meaning architectural register index width.
REQ-004 SHALL derive localparam TAG_W = $clog2(DEPTH), meaning entry tag width.
REQ-005 SHALL have one clock and an asynchronous active-high reset, with ports clock (input, 1, rising-edge clock) and reset (input, 1, async active-high reset).
REQ-006 SHALL provide disp_valid (input, 1, dispatch request), disp_rd_reg (input, REG_W, destination register), disp_pc (input, DATA_W, PC or branch target) and disp_type (input, 2, 00=reg-writing, 01=branch, 10=store).
REQ-007 SHALL provide disp_ready (output, 1, ROB not full) and disp_tag (output, TAG_W, tag allocated to the current dispatch).
REQ-008 SHALL provide rs_reg and rt_reg (input, REG_W, source lookup), plus outputs rs_busy/rt_busy (1, register renamed), rs_tag/rt_tag (TAG_W, producer tag), rs_data_valid/rt_data_valid (1, producer done) and rs_data/rt_data (DATA_W, speculative value).
REQ-009 SHALL provide cdb_valid (input, 1), cdb_tag (input, TAG_W), cdb_data (input, DATA_W) and cdb_branch_taken (input, 1, 1=mispredicted, redirect required).
REQ-010 SHALL provide outputs retire_valid (1), retire_tag (TAG_W), retire_rd_reg (REG_W), retire_data (DATA_W), retire_pc (DATA_W), retire_branch (1), retire_branch_taken (1), retire_store_ready (1), retire_flush (1), empty (1) and full (1).

Function
REQ-011 SHALL hold a circular queue of DEPTH entries with head and tail pointers (TAG_W, wrap DEPTH-1 to 0) and a count register (TAG_W+1); each entry holds rd_reg, pc, type, data, done and taken.
REQ-012 SHALL drive full = (count==DEPTH), empty = (count==0) and disp_ready = !full, all taken from registered state only.
REQ-013 SHALL drive disp_tag = tail combinationally; on disp_valid && !full the entry at tail is written with done=0 and tail advances by 1; disp_valid while full is ignored and leaves no state change.
REQ-014 SHALL, on dispatch with disp_type=00 and disp_rd_reg!=0, set rename_table[disp_rd_reg] = {busy=1, tag=tail}.
REQ-015 SHALL, on cdb_valid, write data and taken into entry cdb_tag and set done=1; a CDB write to an unallocated entry is ignored.
REQ-016 SHALL perform source lookup combinationally: busy/tag come from the rename table before any same-cycle dispatch update; data_valid/data come from the entry's done/data, with a bypass from cdb_data when cdb_valid && cdb_tag==tag.
REQ-017 SHALL retire when !empty and head.done: on that edge, load the head fields into the retire outputs, pulse retire_valid for 1 cycle and advance head (1-cycle latency from done to retire_valid); at most one retire per cycle.
REQ-018 SHALL drive retire_branch = (type==01), retire_store_ready = (type==10), and retire_branch_taken = taken for branches, 0 otherwise.
REQ-019 SHALL clear the rename table entry on retire only if rename_table[rd_reg].tag == retire tag.
REQ-020 SHALL handle simultaneous dispatch and retire with count unchanged; the dispatch condition uses the start-of-cycle full, so no same-cycle slot reuse occurs when full.
REQ-021 SHALL, when a CDB write to head and a retire occur in the same cycle, not retire that entry until the next cycle.

Reset
REQ-022 SHALL, on reset (asynchronous), clear head, tail, count, all done bits, the rename table and all retire_* outputs to 0; empty=1, full=0; reset mid-operation discards all entries.

Configuration
REQ-023 SHALL support macro ROB_FLUSH_EN: when defined, retiring a branch with taken=1 pulses retire_flush for 1 cycle and, on the same edge, sets head=tail=count=0 and clears the rename table and done bits, with any dispatch or CDB write in that cycle discarded.
REQ-024 SHALL, without ROB_FLUSH_EN, tie retire_flush to 0 and report mispredicts only via retire_branch_taken, with no flush.

Structure
REQ-025 SHALL place the inst-type encodings (TYPE_REG, TYPE_BR, TYPE_ST) and the entry struct typedef in shared package rob_pkg.
REQ-026 SHALL implement the rename table as sub-module rob_rename_table (2 read ports, 1 set port, 1 conditional-clear port, flush clear).

Verification
REQ-027 SHALL verify: reset, then dispatch 3 reg ops to r1, r2, r3 -> tags 0, 1, 2; rs_reg=2 gives busy=1, tag=1, data_valid=0.
REQ-028 SHALL verify: CDB tag 1 with data 0xAB before tag 0 -> no retire; then CDB tag 0 with data 0x11 -> retire tag 0 (0x11) followed by tag 1 (0xAB) on consecutive cycles.
REQ-029 SHALL verify: 32 dispatches without retire (DEPTH=32) -> full=1 and disp_ready=0; a 33rd dispatch is ignored; one retire plus same-cycle dispatch -> tag 0 reused, wrap OK.
REQ-030 SHALL verify: r5 dispatched twice (tags 4, 5), then tag 4 retires -> rename_table[r5] stays busy with tag 5.
REQ-031 SHALL verify: CDB tag 3 with data 0x55 in the same cycle as an rs lookup of tag 3 -> rs_data_valid=1 and rs_data=0x55.
REQ-032 SHALL verify, with ROB_FLUSH_EN: a branch at head with cdb_branch_taken=1 and 4 younger entries -> retire_flush=1, then empty=1 and disp_tag=0.
